memory_arbiter: RTL and testbench

Sequencer that shares one single-port unified memory between the instruction-fetch path and the data load/store path of the single-cycle RISC-V core. It sits between the request unit and the memory model. It grants one requester at a time, holds address, data and strobes stable until the memory answers, and returns a one-cycle ready pulse with captured load data. A watchdog aborts transactions the memory never completes.

---
 rtl/core_pkg.sv | 37 +++
 rtl/arb_watchdog.sv | 46 ++++
 rtl/memory_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_memory_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core package.
//   cuOPType            control-unit operation class of the single-cycle core
//   arbState_t          memory arbiter sequencer states
//   arbOp_t             operation latched by the arbiter on a grant
//   ARB_TIMEOUT_DEFAULT default watchdog limit in busy cycles
//   ARB_WDOG_W          width of the arbiter watchdog counter
package core_pkg;

  typedef enum logic [2:0] {
    CU_ALU,
    CU_LOAD,
    CU_STORE,
    CU_BRANCH,
    CU_JUMP
  } cuOPType;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arbState_t;

  typedef enum logic [1:0] {
    ARB_IFETCH,
    ARB_DREAD,
    ARB_DWRITE
  } arbOp_t;

  localparam int ARB_TIMEOUT_DEFAULT = 255;
  localparam int ARB_WDOG_W          = 10;

  // True for operations issued on behalf of the data path.
  function automatic logic arb_is_data(input arbOp_t op);
    return (op != ARB_IFETCH);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Saturating busy-cycle counter for the memory arbiter.
//   CLK      clock
//   RST      synchronous active-high reset
//   clr      clear the count (a new transaction was granted)
//   en       count this cycle (arbiter is waiting on the memory)
//   expired  this enabled cycle is the LIMIT-th one since the last clear
module arb_watchdog
  import core_pkg::*;
#(
  parameter int LIMIT = ARB_TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [ARB_WDOG_W-1:0] CNT_MAX  = '1;
  // The count shows cycles already spent, so the LIMIT-th cycle sees LIMIT-1.
  localparam logic [ARB_WDOG_W-1:0] CNT_LAST = ARB_WDOG_W'(LIMIT - 1);

  logic [ARB_WDOG_W-1:0] count_reg;
  logic [ARB_WDOG_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && (count_reg != CNT_MAX)) begin
      // Saturate instead of wrapping so a stuck access can never re-arm.
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = en && (count_reg >= CNT_LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store.
//   CLK, RST                    clock, synchronous active-high reset
//   imemRen, imemaddr           instruction read request and address
//   dmmRen, dmmWen, dmmaddr,
//   dmmstore                    data read/write request, address, store data
//   mem_ready, mem_rdata        memory completion and read data
//   mem_ren, mem_wen, mem_addr,
//   mem_wdata                   memory strobes, address and write data
//   i_ready, imemload           fetch completion pulse and fetched word
//   d_ready, dmmload            data completion pulse and loaded word
//   bus_err                     pulse with ready when the watchdog aborted
// Every output is a register; a transaction is IDLE -> BUSY (one or more
// cycles) -> RESP (ready pulse) -> IDLE.
module memory_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemRen,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              dmmRen,
  input  logic              dmmWen,
  input  logic [ADDR_W-1:0] dmmaddr,
  input  logic [DATA_W-1:0] dmmstore,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              i_ready,
  output logic [DATA_W-1:0] imemload,
  output logic              d_ready,
  output logic [DATA_W-1:0] dmmload,
  output logic              bus_err
);

  arbState_t         state_reg, state_next;
  arbOp_t            op_reg, op_next;
  logic              last_d_reg, last_d_next;
  logic              mem_ren_reg, mem_ren_next;
  logic              mem_wen_reg, mem_wen_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              i_ready_reg, i_ready_next;
  logic              d_ready_reg, d_ready_next;
  logic              bus_err_reg, bus_err_next;
  logic [DATA_W-1:0] imemload_reg, imemload_next;
  logic [DATA_W-1:0] dmmload_reg, dmmload_next;

  logic d_req;
  logic pick_ifetch;
  logic grant;
  logic wd_expired;

  assign d_req = dmmRen || dmmWen;
  // Data normally wins; a fetch pending right after a data grant goes first
  // so a store/load burst cannot starve the instruction stream.
  assign pick_ifetch = imemRen && (!d_req || last_d_reg);

  arb_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (grant),
    .en      (state_reg == BUSY),
    .expired (wd_expired)
  );

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    last_d_next   = last_d_reg;
    mem_ren_next  = mem_ren_reg;
    mem_wen_next  = mem_wen_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    i_ready_next  = 1'b0;
    d_ready_next  = 1'b0;
    bus_err_next  = 1'b0;
    imemload_next = imemload_reg;
    dmmload_next  = dmmload_reg;
    grant         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (imemRen || d_req) begin
          grant       = 1'b1;
          state_next  = BUSY;
          wdata_next  = dmmstore;
          last_d_next = !pick_ifetch;
          if (pick_ifetch) begin
            op_next      = ARB_IFETCH;
            addr_next    = imemaddr;
            mem_ren_next = 1'b1;
            mem_wen_next = 1'b0;
          end else if (dmmWen) begin
            // A simultaneous read request is dropped; the write is performed.
            op_next      = ARB_DWRITE;
            addr_next    = dmmaddr;
            mem_ren_next = 1'b0;
            mem_wen_next = 1'b1;
          end else begin
            op_next      = ARB_DREAD;
            addr_next    = dmmaddr;
            mem_ren_next = 1'b1;
            mem_wen_next = 1'b0;
          end
        end
      end

      BUSY: begin
        // A memory answer on the timeout cycle still counts as a completion.
        if (mem_ready || wd_expired) begin
          state_next   = RESP;
          mem_ren_next = 1'b0;
          mem_wen_next = 1'b0;
          bus_err_next = !mem_ready;
          i_ready_next = !arb_is_data(op_reg);
          d_ready_next = arb_is_data(op_reg);
          if (op_reg == ARB_IFETCH) begin
            imemload_next = mem_ready ? mem_rdata : '0;
          end else if (op_reg == ARB_DREAD) begin
            dmmload_next = mem_ready ? mem_rdata : '0;
          end
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      op_reg       <= ARB_IFETCH;
      last_d_reg   <= 1'b0;
      mem_ren_reg  <= 1'b0;
      mem_wen_reg  <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      i_ready_reg  <= 1'b0;
      d_ready_reg  <= 1'b0;
      bus_err_reg  <= 1'b0;
      imemload_reg <= '0;
      dmmload_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      last_d_reg   <= last_d_next;
      mem_ren_reg  <= mem_ren_next;
      mem_wen_reg  <= mem_wen_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      i_ready_reg  <= i_ready_next;
      d_ready_reg  <= d_ready_next;
      bus_err_reg  <= bus_err_next;
      imemload_reg <= imemload_next;
      dmmload_reg  <= dmmload_next;
    end
  end

  assign mem_ren   = mem_ren_reg;
  assign mem_wen   = mem_wen_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign i_ready   = i_ready_reg;
  assign d_ready   = d_ready_reg;
  assign bus_err   = bus_err_reg;
  assign imemload  = imemload_reg;
  assign dmmload   = dmmload_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus randomized transactions,
// checked cycle by cycle against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemRen = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        dmmRen = 1'b0;
  logic        dmmWen = 1'b0;
  logic [31:0] dmmaddr = '0;
  logic [31:0] dmmstore = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ren, mem_wen, i_ready, d_ready, bus_err;
  logic [31:0] mem_addr, mem_wdata, imemload, dmmload;

  memory_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .imemRen   (imemRen),
    .imemaddr  (imemaddr),
    .dmmRen    (dmmRen),
    .dmmWen    (dmmWen),
    .dmmaddr   (dmmaddr),
    .dmmstore  (dmmstore),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .i_ready   (i_ready),
    .imemload  (imemload),
    .d_ready   (d_ready),
    .dmmload   (dmmload),
    .bus_err   (bus_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  // Reference model state: who was granted last and what the loads hold.
  bit          m_last_d = 1'b0;
  logic [31:0] m_iload  = '0;
  logic [31:0] m_dload  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_last_d = 1'b0;
    m_iload  = '0;
    m_dload  = '0;
  endtask

  // One complete transaction starting at a negedge with the arbiter idle.
  // delay = busy cycle on which the memory answers; 0 = never answers.
  task automatic do_txn(input bit ir, input bit dr, input bit dw,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] wd, input int delay,
                        input logic [31:0] rd);
    bit          exp_i;
    bit          exp_w;
    bit          to;
    int          nb;
    logic [31:0] exp_addr;
    exp_i    = ir && (!(dr || dw) || m_last_d);
    exp_w    = !exp_i && dw;
    exp_addr = exp_i ? ia : da;
    to       = (delay == 0) || (delay > TO);
    nb       = to ? TO : delay;
    m_last_d = !exp_i;

    imemRen = ir; dmmRen = dr; dmmWen = dw;
    imemaddr = ia; dmmaddr = da; dmmstore = wd;
    mem_ready = 1'b0;
    @(negedge CLK);
    for (int k = 1; k <= nb; k++) begin
      check("busy_ren", 32'(mem_ren), 32'(!exp_w));
      check("busy_wen", 32'(mem_wen), 32'(exp_w));
      check("busy_addr", mem_addr, exp_addr);
      if (exp_w) check("busy_wdata", mem_wdata, wd);
      check("busy_rdy", {29'b0, i_ready, d_ready, bus_err}, 32'd0);
      // Requester activity while busy must not disturb the access.
      imemRen  = 1'($urandom);
      dmmRen   = 1'($urandom);
      dmmWen   = 1'($urandom);
      imemaddr = $urandom();
      dmmaddr  = $urandom();
      dmmstore = $urandom();
      mem_ready = (k == delay);
      mem_rdata = (k == delay) ? rd : $urandom();
      @(negedge CLK);
    end
    // Ready pulse cycle; memory activity here must be ignored.
    imemRen = 1'b0; dmmRen = 1'b0; dmmWen = 1'b0;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom();
    if (exp_i) m_iload = to ? 32'd0 : rd;
    else if (!exp_w) m_dload = to ? 32'd0 : rd;
    check("resp_iready", 32'(i_ready), 32'(exp_i));
    check("resp_dready", 32'(d_ready), 32'(!exp_i));
    check("resp_buserr", 32'(bus_err), 32'(to));
    check("resp_strobes", {30'b0, mem_ren, mem_wen}, 32'd0);
    check("resp_imemload", imemload, m_iload);
    check("resp_dmmload", dmmload, m_dload);
    $display("txn %0d: %s addr=%h busy=%0d err=%0b", n_txn,
             exp_i ? "ifetch" : (exp_w ? "dwrite" : "dread "), exp_addr, nb, to);
    n_txn++;
    @(negedge CLK);
    mem_ready = 1'b0;
    check("idle_rdy", {29'b0, i_ready, d_ready, bus_err}, 32'd0);
    check("idle_strobes", {30'b0, mem_ren, mem_wen}, 32'd0);
  endtask

  // Idle cycles with stray mem_ready pulses that must be ignored.
  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      mem_ready = 1'($urandom);
      @(negedge CLK);
      check("gap_strobes", {30'b0, mem_ren, mem_wen}, 32'd0);
      check("gap_rdy", {29'b0, i_ready, d_ready, bus_err}, 32'd0);
    end
    mem_ready = 1'b0;
  endtask

  task automatic reset_mid_write();
    imemRen = 1'b0; dmmRen = 1'b0; dmmWen = 1'b1;
    dmmaddr = 32'h0000_0300; dmmstore = 32'h1234_5678;
    mem_ready = 1'b0;
    m_last_d = 1'b1;
    @(negedge CLK);
    check("rst_busy1_wen", 32'(mem_wen), 32'd1);
    @(negedge CLK);
    check("rst_busy2_wen", 32'(mem_wen), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    model_reset();
    check("rst_strobes", {30'b0, mem_ren, mem_wen}, 32'd0);
    check("rst_rdy", {29'b0, i_ready, d_ready, bus_err}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_dmmload", dmmload, m_dload);
    check("rst_imemload", imemload, m_iload);
    RST = 1'b0;
    dmmWen = 1'b0;
    @(negedge CLK);
    check("rst_after_rdy", {29'b0, i_ready, d_ready, bus_err}, 32'd0);
    check("rst_after_strobes", {30'b0, mem_ren, mem_wen}, 32'd0);
    $display("txn %0d: dwrite addr=00000300 abandoned by reset", n_txn);
    n_txn++;
  endtask

  initial begin
    #200000;
    $display("FAIL bench_timeout: got no finish expected finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    bit          ir, dr, dw;
    int          dly;
    logic [31:0] rd;

    // Reset held two cycles with every request asserted.
    RST = 1'b1; imemRen = 1'b1; dmmRen = 1'b1; dmmWen = 1'b1;
    imemaddr = 32'h0000_0000; dmmaddr = 32'h0000_0100; dmmstore = 32'hA5A5_0001;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check("reset_strobes", {30'b0, mem_ren, mem_wen}, 32'd0);
      check("reset_rdy", {29'b0, i_ready, d_ready, bus_err}, 32'd0);
      check("reset_addr", mem_addr, 32'd0);
      check("reset_wdata", mem_wdata, 32'd0);
      check("reset_imemload", imemload, 32'd0);
      check("reset_dmmload", dmmload, 32'd0);
    end
    RST = 1'b0;

    // Contention: data, instruction, data.
    do_txn(1, 1, 1, 32'h0000_0000, 32'h0000_0100, 32'hA5A5_0001, 1, 32'h0);
    do_txn(1, 1, 1, 32'h0000_0004, 32'h0000_0104, 32'hA5A5_0002, 2, 32'h0000_0013);
    do_txn(1, 1, 0, 32'h0000_0008, 32'h0000_0100, 32'h0, 1, 32'hCAFE_0100);

    // Lone fetch answered on the third busy cycle.
    do_txn(1, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 3, 32'h0051_3023);

    // Read and write together: the write is performed, dmmload untouched.
    do_txn(0, 1, 1, 32'h0, 32'h0000_0200, 32'hDEAD_BEEF, 2, 32'h7777_7777);

    // Watchdog: never answered, answered on the last cycle, answered too late.
    do_txn(0, 1, 0, 32'h0, 32'h0000_0204, 32'h0, 0, 32'h0);
    do_txn(0, 1, 0, 32'h0, 32'h0000_0208, 32'h0, TO, 32'h1357_9BDF);
    do_txn(1, 0, 0, 32'h0000_0044, 32'h0, 32'h0, TO + 1, 32'h2468_ACE0);

    idle_gap(3);
    reset_mid_write();
    idle_gap(2);

    for (int t = 0; t < 40; t++) begin
      ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
      if (!(ir || dr || dw)) ir = 1'b1;
      dly = $urandom_range(0, TO + 2);
      rd  = $urandom();
      do_txn(ir, dr, dw, $urandom(), $urandom(), $urandom(), dly, rd);
      if (t % 8 == 7) idle_gap(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
